dec_req_scheduler: RTL and testbench
====================================

# dec_req_scheduler

Sequencing and arbitration controller for the shared decoder output datapath. Two requesters submit codewords over valid/ready handshakes. The block grants one of them round-robin, drives the codeword into the combinational decode datapath, and captures the corrected data and error classification. It returns the result on a single response channel tagged with the requester id, and keeps saturating error statistics.

## Interface
- DATA_WIDTH, 32, codeword/data width (matches the decode datapath)
- CNT_WIDTH, 16, width of each error-statistics counter

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a codeword
- req0_codeword  in  DATA_WIDTH  requester 0 codeword
- req0_ready  out  1  requester 0 accepted this cycle when high with req0_valid
- req1_valid / req1_codeword / req1_ready  same as requester 0
- dp_codeword  out  DATA_WIDTH  registered codeword driven into decode datapath
- dp_num_of_errors  in  2  datapath classification: 00 none, 01 single corrected, 10 uncorrectable
- dp_data_out  in  DATA_WIDTH  datapath corrected data
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that owns the response
- rsp_data  out  DATA_WIDTH  captured dp_data_out
- rsp_num_of_errors  out  2  captured dp_num_of_errors
- cnt_clear  in  1  synchronous clear of both counters
- single_err_cnt  out  CNT_WIDTH  responses classified 01
- double_err_cnt  out  CNT_WIDTH  responses classified 10 or 11
- busy  out  1  state != IDLE

## Operation
- FSM states:
  - IDLE: wait for a request. Go to DECODE on accept.
  - DECODE: one cycle. Datapath settles and results are captured at the end of the cycle. Go to RESP unconditionally.
  - RESP: hold the response until rsp_valid & rsp_ready, then go to IDLE.
- Grant, combinational, evaluated only in IDLE:
  - Only one requester valid: grant it.
  - Both valid: grant the requester not equal to last_grant.
  - reqN_ready = (state==IDLE) & (grant==N). Both readys are 0 outside IDLE.
- Accept = reqN_valid & reqN_ready. On accept:
  - dp_codeword <= reqN_codeword
  - rsp_id <= N
  - last_grant <= N
- DECODE end:
  - rsp_data <= dp_data_out
  - rsp_num_of_errors <= dp_num_of_errors
- Counter updates, applied at the DECODE end:
  - 01: increment single_err_cnt.
  - 10 or 11: increment double_err_cnt. 11 is illegal and is counted as uncorrectable.
  - 00: no change.
- Counters saturate at all-ones and never wrap.
- cnt_clear in the same cycle as an increment: clear wins, and the counter becomes 0, not 1.
- dp_codeword, rsp_data, rsp_num_of_errors and rsp_id hold their values until overwritten. Holding has no functional effect outside RESP.
- Requester valid deasserted before accept: no effect, no grant recorded.

## Timing
- Reset (rst low, asynchronous):
  - state=IDLE, last_grant=1, so requester 0 wins the first tie.
  - All outputs 0, including dp_codeword, rsp_*, and both counters.
  - Reset release is synchronous to clk.
- Accept in cycle T: DECODE in T+1, rsp_valid=1 from T+2.
- Minimum spacing between accepts is 3 cycles: accept in the IDLE cycle, DECODE, then a RESP cycle with rsp_ready=1.
- rsp_ready stalled: the block stays in RESP. rsp_* outputs are stable and rsp_valid stays high.
- Response handshake in cycle T: IDLE in T+1, next accept possible in T+1. There is no IDLE bypass.
- rst asserted mid-DECODE or mid-RESP:
  - The in-flight response is dropped and counters are cleared.
  - The requester has already been handed off and is not re-notified.

## Structure
- Package dec_ctrl_pkg:
  - state enum {IDLE, DECODE, RESP}
  - localparams NUM_ERR_NONE=2'b00, NUM_ERR_SINGLE=2'b01, NUM_ERR_DOUBLE=2'b10
- Sub-module dec_rr_arbiter, 2-way round-robin:
  - Inputs: valids, last_grant, enable.
  - Outputs: grant index, grant_valid.
  - Purely combinational. last_grant is registered in the parent.
- The decode datapath stays external. This block only drives and samples it.

## Test plan
- Reset: hold rst low with req0_valid=1. All readys 0, rsp_valid 0, counters 0, busy 0. After release, req0 is accepted on the first edge.
- Single request: req1_codeword=32'hA5A5_0001 accepted at T, datapath returns 01/32'hA5A5_0000. rsp_valid at T+2 with rsp_id=1, rsp_num_of_errors=01, rsp_data=32'hA5A5_0000. single_err_cnt=1.
- Contention: both valid continuously, rsp_ready=1. Grants alternate 0,1,0,1 with one accept every 3 cycles.
- Back-pressure: rsp_ready=0 for 5 cycles. rsp_* stable, readys 0, no new accept. Handshake on cycle 6, IDLE on the next cycle.
- Counter boundary:
  - Preload double_err_cnt to 16'hFFFF via repeated 10 results. A further 10 keeps it at 16'hFFFF.
  - cnt_clear coincident with a 01 capture gives single_err_cnt=0.
- Mid-operation reset: assert rst during RESP. rsp_valid drops immediately (asynchronous), state IDLE, counters 0.

Source files
------------

// File: rtl/dec_ctrl_pkg.sv
// Shared types and constants for the decoder request scheduler.
package dec_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [1:0] NUM_ERR_NONE   = 2'b00;
  localparam logic [1:0] NUM_ERR_SINGLE = 2'b01;
  localparam logic [1:0] NUM_ERR_DOUBLE = 2'b10;

  // 2'b11 never comes from a healthy datapath; treat it as uncorrectable.
  function automatic logic is_uncorrectable(input logic [1:0] n);
    return n[1];
  endfunction

endpackage

// File: rtl/dec_req_scheduler_if.sv
// Requester and response handshake bundle for the decoder scheduler.
interface dec_req_scheduler_if #(parameter int DATA_WIDTH = 32);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [DATA_WIDTH-1:0] req0_codeword;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [DATA_WIDTH-1:0] req1_codeword;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [1:0]            rsp_num_of_errors;

  modport slave (
    input  req0_valid, req0_codeword, req1_valid, req1_codeword, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_num_of_errors
  );

  modport master (
    output req0_valid, req0_codeword, req1_valid, req1_codeword, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_num_of_errors
  );
endinterface

// File: rtl/dec_rr_arbiter.sv
// Two-way round-robin grant; the last-grant pointer lives in the parent.
module dec_rr_arbiter (
  input  logic [1:0] valids,
  input  logic       last_grant,
  input  logic       enable,
  output logic       grant,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = enable & (|valids);
    if (&valids) grant = ~last_grant;
    else         grant = valids[1];
  end

endmodule

// File: rtl/dec_req_scheduler.sv
// Arbitrates two codeword requesters onto the external decode datapath and
// returns tagged results with saturating error statistics.
module dec_req_scheduler
  import dec_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  dec_req_scheduler_if.slave    bus,
  output logic [DATA_WIDTH-1:0] dp_codeword,
  input  logic [1:0]            dp_num_of_errors,
  input  logic [DATA_WIDTH-1:0] dp_data_out,
  input  logic                  cnt_clear,
  output logic [CNT_WIDTH-1:0]  single_err_cnt,
  output logic [CNT_WIDTH-1:0]  double_err_cnt,
  output logic                  busy
);

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] dp_codeword_q, dp_codeword_d;
  logic                  rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]            rsp_nerr_q, rsp_nerr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  busy_q, busy_d;
  logic [CNT_WIDTH-1:0]  single_q, single_d;
  logic [CNT_WIDTH-1:0]  double_q, double_d;

  logic grant, grant_valid;

  // Gating with rst keeps both readys low while reset is held.
  dec_rr_arbiter u_arb (
    .valids      ({bus.req1_valid, bus.req0_valid}),
    .last_grant  (last_grant_q),
    .enable      ((state_q == IDLE) & rst),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign bus.req0_ready = grant_valid & ~grant;
  assign bus.req1_ready = grant_valid &  grant;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    dp_codeword_d = dp_codeword_q;
    rsp_id_d      = rsp_id_q;
    rsp_data_d    = rsp_data_q;
    rsp_nerr_d    = rsp_nerr_q;
    rsp_valid_d   = rsp_valid_q;
    busy_d        = busy_q;
    case (state_q)
      IDLE: if (grant_valid) begin
        state_d       = DECODE;
        dp_codeword_d = grant ? bus.req1_codeword : bus.req0_codeword;
        rsp_id_d      = grant;
        last_grant_d  = grant;
        busy_d        = 1'b1;
      end
      DECODE: begin
        state_d     = RESP;
        rsp_data_d  = dp_data_out;
        rsp_nerr_d  = dp_num_of_errors;
        rsp_valid_d = 1'b1;
      end
      RESP: if (bus.rsp_ready) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // Clear dominates a same-cycle increment; both counters stick at all-ones.
  always_comb begin
    single_d = single_q;
    double_d = double_q;
    if (cnt_clear) begin
      single_d = '0;
      double_d = '0;
    end else if (state_q == DECODE) begin
      if (dp_num_of_errors == NUM_ERR_SINGLE && single_q != '1)
        single_d = single_q + CNT_WIDTH'(1);
      if (is_uncorrectable(dp_num_of_errors) && double_q != '1)
        double_d = double_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      dp_codeword_q <= '0;
      rsp_id_q      <= 1'b0;
      rsp_data_q    <= '0;
      rsp_nerr_q    <= NUM_ERR_NONE;
      rsp_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      single_q      <= '0;
      double_q      <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      dp_codeword_q <= dp_codeword_d;
      rsp_id_q      <= rsp_id_d;
      rsp_data_q    <= rsp_data_d;
      rsp_nerr_q    <= rsp_nerr_d;
      rsp_valid_q   <= rsp_valid_d;
      busy_q        <= busy_d;
      single_q      <= single_d;
      double_q      <= double_d;
    end
  end

  assign dp_codeword           = dp_codeword_q;
  assign bus.rsp_valid         = rsp_valid_q;
  assign bus.rsp_id            = rsp_id_q;
  assign bus.rsp_data          = rsp_data_q;
  assign bus.rsp_num_of_errors = rsp_nerr_q;
  assign single_err_cnt        = single_q;
  assign double_err_cnt        = double_q;
  assign busy                  = busy_q;

endmodule

// File: tb/tb_dec_req_scheduler.sv
// Directed bench for dec_req_scheduler; counters run 4 bits wide so
// saturation is reachable in a handful of transactions.
module tb_dec_req_scheduler;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] dp_codeword;
  logic [1:0]    dp_num_of_errors;
  logic [DW-1:0] dp_data_out;
  logic          cnt_clear;
  logic [CW-1:0] single_err_cnt, double_err_cnt;
  logic          busy;

  int total = 0;
  int bad   = 0;

  dec_req_scheduler_if #(.DATA_WIDTH(DW)) bus ();

  dec_req_scheduler #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus.slave),
    .dp_codeword      (dp_codeword),
    .dp_num_of_errors (dp_num_of_errors),
    .dp_data_out      (dp_data_out),
    .cnt_clear        (cnt_clear),
    .single_err_cnt   (single_err_cnt),
    .double_err_cnt   (double_err_cnt),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk); #1;
  endtask

  // Stimulus only: one requester-0 transaction with rsp_ready held high.
  task automatic run_txn(input logic [DW-1:0] cw, input logic [1:0] ne, input logic [DW-1:0] d);
    bus.req0_valid = 1'b1; bus.req0_codeword = cw;
    dp_num_of_errors = ne; dp_data_out = d; bus.rsp_ready = 1'b1;
    step; bus.req0_valid = 1'b0;
    step;
    step; bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_codeword = 32'h0000_0011;
    repeat (3) step;
    total++; if (bus.req0_ready !== 1'b0) begin bad++; $display("FAIL rst_ready0 got=%0b want=0", bus.req0_ready); end
    total++; if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL rst_ready1 got=%0b want=0", bus.req1_ready); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%0b want=0", bus.rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
    total++; if ({single_err_cnt, double_err_cnt} !== 8'h00) begin bad++; $display("FAIL rst_cnts got=%h want=00", {single_err_cnt, double_err_cnt}); end
    total++; if (dp_codeword !== 32'h0) begin bad++; $display("FAIL rst_dp_codeword got=%h want=0", dp_codeword); end
    rst = 1'b1; #1;
    total++; if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL rel_ready0 got=%0b want=1", bus.req0_ready); end
    step; bus.req0_valid = 1'b0;
    total++; if (busy !== 1'b1 || dp_codeword !== 32'h0000_0011) begin bad++; $display("FAIL rel_accept busy=%0b cw=%h want 1/00000011", busy, dp_codeword); end
    step;
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0) begin bad++; $display("FAIL rel_rsp valid=%0b id=%0b want 1/0", bus.rsp_valid, bus.rsp_id); end
    bus.rsp_ready = 1'b1;
    step; bus.rsp_ready = 1'b0;
    total++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rel_idle busy=%0b valid=%0b want 0/0", busy, bus.rsp_valid); end
  endtask

  task automatic test_single;
    bus.req1_valid = 1'b1; bus.req1_codeword = 32'hA5A5_0001;
    dp_num_of_errors = 2'b01; dp_data_out = 32'hA5A5_0000; #1;
    total++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin bad++; $display("FAIL single_ready r1=%0b r0=%0b want 1/0", bus.req1_ready, bus.req0_ready); end
    step; bus.req1_valid = 1'b0;
    total++; if (dp_codeword !== 32'hA5A5_0001) begin bad++; $display("FAIL single_dp_cw got=%h want=a5a50001", dp_codeword); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%0b want=0", bus.rsp_valid); end
    step;
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1) begin bad++; $display("FAIL single_rsp valid=%0b id=%0b want 1/1", bus.rsp_valid, bus.rsp_id); end
    total++; if (bus.rsp_num_of_errors !== 2'b01 || bus.rsp_data !== 32'hA5A5_0000) begin bad++; $display("FAIL single_rsp_data ne=%b d=%h want 01/a5a50000", bus.rsp_num_of_errors, bus.rsp_data); end
    total++; if (single_err_cnt !== 4'd1 || double_err_cnt !== 4'd0) begin bad++; $display("FAIL single_cnt s=%0d d=%0d want 1/0", single_err_cnt, double_err_cnt); end
    bus.rsp_ready = 1'b1;
    step; bus.rsp_ready = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle busy=%0b want 0", busy); end
  endtask

  task automatic test_contention;
    logic [DW-1:0] cws [2];
    cws[0] = 32'h0000_00C0; cws[1] = 32'h0000_00C1;
    bus.req0_valid = 1'b1; bus.req0_codeword = cws[0];
    bus.req1_valid = 1'b1; bus.req1_codeword = cws[1];
    bus.rsp_ready = 1'b1; dp_num_of_errors = 2'b00; dp_data_out = 32'h0;
    #1;
    for (int k = 0; k < 4; k++) begin
      logic e;
      e = k[0];
      total++; if ({bus.req1_ready, bus.req0_ready} !== (e ? 2'b10 : 2'b01)) begin bad++; $display("FAIL cont_ready k=%0d got=%b want=%b", k, {bus.req1_ready, bus.req0_ready}, e ? 2'b10 : 2'b01); end
      step;
      total++; if (dp_codeword !== cws[e] || busy !== 1'b1) begin bad++; $display("FAIL cont_dp k=%0d cw=%h busy=%0b want %h/1", k, dp_codeword, busy, cws[e]); end
      step;
      total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== e) begin bad++; $display("FAIL cont_rsp k=%0d valid=%0b id=%0b want 1/%0b", k, bus.rsp_valid, bus.rsp_id, e); end
      step;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL cont_idle k=%0d busy=%0b want 0", k, busy); end
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    bus.req0_valid = 1'b1; bus.req0_codeword = 32'hBEEF_0000;
    dp_num_of_errors = 2'b10; dp_data_out = 32'hDEAD_0001;
    step;
    bus.req0_codeword = 32'h1234_5678; bus.req1_valid = 1'b1;
    step;
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hDEAD_0001 || bus.rsp_num_of_errors !== 2'b10 || bus.rsp_id !== 1'b0) begin bad++; $display("FAIL bp_hold i=%0d v=%0b d=%h ne=%b id=%0b want 1/dead0001/10/0", i, bus.rsp_valid, bus.rsp_data, bus.rsp_num_of_errors, bus.rsp_id); end
      total++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00 || dp_codeword !== 32'hBEEF_0000) begin bad++; $display("FAIL bp_noacc i=%0d rdy=%b cw=%h want 00/beef0000", i, {bus.req1_ready, bus.req0_ready}, dp_codeword); end
      step;
    end
    bus.rsp_ready = 1'b1;
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_c6 valid=%0b want 1", bus.rsp_valid); end
    step;
    total++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_idle busy=%0b valid=%0b want 0/0", busy, bus.rsp_valid); end
    total++; if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin bad++; $display("FAIL bp_rr rdy=%b want 10", {bus.req1_ready, bus.req0_ready}); end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b0;
    total++; if (double_err_cnt !== 4'd1) begin bad++; $display("FAIL bp_dcnt got=%0d want 1", double_err_cnt); end
  endtask

  task automatic test_counter_boundary;
    cnt_clear = 1'b1; step; cnt_clear = 1'b0;
    total++; if (single_err_cnt !== 4'd0 || double_err_cnt !== 4'd0) begin bad++; $display("FAIL clr s=%0d d=%0d want 0/0", single_err_cnt, double_err_cnt); end
    for (int i = 0; i < 14; i++) run_txn(32'h0000_1000 + DW'(i), (i == 13) ? 2'b11 : 2'b10, 32'h0);
    total++; if (double_err_cnt !== 4'd14) begin bad++; $display("FAIL dcnt14 got=%0d want 14", double_err_cnt); end
    run_txn(32'h0000_2000, 2'b10, 32'h0);
    total++; if (double_err_cnt !== 4'hF) begin bad++; $display("FAIL dcnt_full got=%0d want 15", double_err_cnt); end
    run_txn(32'h0000_2001, 2'b10, 32'h0);
    total++; if (double_err_cnt !== 4'hF || single_err_cnt !== 4'd0) begin bad++; $display("FAIL dcnt_sat d=%0d s=%0d want 15/0", double_err_cnt, single_err_cnt); end
    run_txn(32'h0000_3000, 2'b01, 32'h0);
    total++; if (single_err_cnt !== 4'd1) begin bad++; $display("FAIL scnt1 got=%0d want 1", single_err_cnt); end
    bus.req0_valid = 1'b1; bus.req0_codeword = 32'h0000_3001; dp_num_of_errors = 2'b01;
    step; bus.req0_valid = 1'b0; cnt_clear = 1'b1;
    step; cnt_clear = 1'b0;
    total++; if (single_err_cnt !== 4'd0 || double_err_cnt !== 4'd0) begin bad++; $display("FAIL clr_wins s=%0d d=%0d want 0/0", single_err_cnt, double_err_cnt); end
    total++; if (bus.rsp_num_of_errors !== 2'b01) begin bad++; $display("FAIL clr_capture ne=%b want 01", bus.rsp_num_of_errors); end
    bus.rsp_ready = 1'b1; step; bus.rsp_ready = 1'b0;
  endtask

  task automatic test_mid_reset;
    bus.req1_valid = 1'b1; bus.req1_codeword = 32'h0F0F_0F0F;
    dp_num_of_errors = 2'b01; dp_data_out = 32'h0F0F_0F0E;
    step; bus.req1_valid = 1'b0;
    step;
    total++; if (bus.rsp_valid !== 1'b1 || single_err_cnt !== 4'd1) begin bad++; $display("FAIL mr_pre valid=%0b s=%0d want 1/1", bus.rsp_valid, single_err_cnt); end
    rst = 1'b0; #1;
    total++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mr_async valid=%0b busy=%0b want 0/0", bus.rsp_valid, busy); end
    total++; if (single_err_cnt !== 4'd0 || dp_codeword !== 32'h0 || bus.rsp_id !== 1'b0) begin bad++; $display("FAIL mr_clear s=%0d cw=%h id=%0b want 0/0/0", single_err_cnt, dp_codeword, bus.rsp_id); end
    step; rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; #1;
    total++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin bad++; $display("FAIL mr_tie rdy=%b want 01", {bus.req1_ready, bus.req0_ready}); end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    step;
    total++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL mr_idle busy=%0b valid=%0b want 0/0", busy, bus.rsp_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; cnt_clear = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_codeword = '0;
    bus.req1_valid = 1'b0; bus.req1_codeword = '0;
    bus.rsp_ready = 1'b0;
    dp_num_of_errors = 2'b00; dp_data_out = '0;
    test_reset;
    test_single;
    test_contention;
    test_backpressure;
    test_counter_boundary;
    test_mid_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
